// File: rtl/l1_ahb_mtx_pkg.sv
// Shared AHB matrix encodings: transfer/burst/response codes, input-stage FSM states
// and the captured address-phase record.
package l1_ahb_mtx_pkg;

   localparam int unsigned AHB_ADDR_W = 32;
   localparam int unsigned AHB_DATA_W = 32;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PEND = 2'b01,
      ST_DATA = 2'b10
   } mtx_state_e;

   typedef struct packed {
      logic [AHB_ADDR_W-1:0] addr;
      logic [AHB_ADDR_W-1:0] auser;
      logic [1:0]            trans;
      logic                  write;
      logic [2:0]            size;
      logic [2:0]            burst;
      logic [3:0]            prot;
      logic [3:0]            master;
      logic                  mastlock;
   } addr_ctrl_t;

   // A held SEQ beat loses its burst context once stalled, so it is reissued as a
   // standalone NONSEQ of an undefined-length INCR burst.
   function automatic addr_ctrl_t promote_held(input addr_ctrl_t c);
      addr_ctrl_t r;
      r = c;
      if (c.trans == HTRANS_SEQ) begin
         r.trans = HTRANS_NONSEQ;
         r.burst = HBURST_INCR;
      end
      return r;
   endfunction

endpackage

// File: rtl/l1_ahb_mtx_in_stg_if.sv
// Signal bundle between an AHB master port, its matrix input stage and the
// output stages/decoder behind it.
interface l1_ahb_mtx_in_stg_if;
   import l1_ahb_mtx_pkg::*;

   logic                  HSELS;
   logic [AHB_ADDR_W-1:0] HADDRS;
   logic [AHB_ADDR_W-1:0] HAUSERS;
   logic [AHB_DATA_W-1:0] HWUSERS;
   logic [AHB_DATA_W-1:0] HWDATAS;
   logic [1:0]            HTRANSS;
   logic                  HWRITES;
   logic [2:0]            HSIZES;
   logic [2:0]            HBURSTS;
   logic [3:0]            HPROTS;
   logic [3:0]            HMASTERS;
   logic                  HMASTLOCKS;
   logic                  HREADYS;

   logic                  active_in;
   logic                  hready_in;
   logic                  readyout_in;
   logic [1:0]            resp_in;

   logic                  sel_in;
   logic [AHB_ADDR_W-1:0] addr_in;
   logic [AHB_ADDR_W-1:0] auser_in;
   logic [1:0]            trans_in;
   logic                  write_in;
   logic [2:0]            size_in;
   logic [2:0]            burst_in;
   logic [3:0]            prot_in;
   logic [3:0]            master_in;
   logic                  mastlock_in;
   logic [AHB_DATA_W-1:0] wdata_in;
   logic [AHB_DATA_W-1:0] wuser_in;
   logic                  held_tran_in;
   logic                  HREADYOUTS;
   logic [1:0]            HRESPS;

   modport slave (
      input  HSELS, HADDRS, HAUSERS, HWUSERS, HWDATAS, HTRANSS, HWRITES, HSIZES,
             HBURSTS, HPROTS, HMASTERS, HMASTLOCKS, HREADYS,
             active_in, hready_in, readyout_in, resp_in,
      output sel_in, addr_in, auser_in, trans_in, write_in, size_in, burst_in,
             prot_in, master_in, mastlock_in, wdata_in, wuser_in, held_tran_in,
             HREADYOUTS, HRESPS
   );

   modport master (
      output HSELS, HADDRS, HAUSERS, HWUSERS, HWDATAS, HTRANSS, HWRITES, HSIZES,
             HBURSTS, HPROTS, HMASTERS, HMASTLOCKS, HREADYS,
             active_in, hready_in, readyout_in, resp_in,
      input  sel_in, addr_in, auser_in, trans_in, write_in, size_in, burst_in,
             prot_in, master_in, mastlock_in, wdata_in, wuser_in, held_tran_in,
             HREADYOUTS, HRESPS
   );

endinterface

// File: rtl/l1_ahb_mtx_in_stg.sv
// AHB matrix input stage: forwards a master's address phase to the output stages,
// holding it and stalling the master while the output stage has not granted it.
module l1_ahb_mtx_in_stg
   import l1_ahb_mtx_pkg::*;
(
   input  logic                HCLK,
   input  logic                HRESETn,
   l1_ahb_mtx_in_stg_if.slave  bus
);

   mtx_state_e state_q, state_d;
   addr_ctrl_t hold_q;
   addr_ctrl_t live_c;
   addr_ctrl_t out_c;
   logic       trans_req;
   logic       held_tran;
   logic       accept;
   logic       in_pend;
   logic       hold_load;

   always_comb begin
      live_c          = '0;
      live_c.addr     = bus.HADDRS;
      live_c.auser    = bus.HAUSERS;
      live_c.trans    = bus.HTRANSS;
      live_c.write    = bus.HWRITES;
      live_c.size     = bus.HSIZES;
      live_c.burst    = bus.HBURSTS;
      live_c.prot     = bus.HPROTS;
      live_c.master   = bus.HMASTERS;
      live_c.mastlock = bus.HMASTLOCKS;
   end

   assign in_pend   = (state_q == ST_PEND);
   assign trans_req = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
   // Reset gating keeps a live request from reaching the output stages during reset.
   assign held_tran = HRESETn & (trans_req | in_pend);
   assign accept    = held_tran & bus.active_in & bus.hready_in;
   assign hold_load = trans_req & ~in_pend;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         if (hold_load) begin
            hold_q <= live_c;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (trans_req) begin
               state_d = accept ? ST_DATA : ST_PEND;
            end
         end
         ST_PEND: begin
            if (accept) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            // Once the current data phase completes, the new address phase is
            // treated exactly as it would be from IDLE.
            if (bus.readyout_in) begin
               if (trans_req) begin
                  state_d = accept ? ST_DATA : ST_PEND;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign out_c = in_pend ? promote_held(hold_q) : live_c;

   assign bus.sel_in       = in_pend ? 1'b1 : bus.HSELS;
   assign bus.addr_in      = out_c.addr;
   assign bus.auser_in     = out_c.auser;
   assign bus.trans_in     = out_c.trans;
   assign bus.write_in     = out_c.write;
   assign bus.size_in      = out_c.size;
   assign bus.burst_in     = out_c.burst;
   assign bus.prot_in      = out_c.prot;
   assign bus.master_in    = out_c.master;
   assign bus.mastlock_in  = out_c.mastlock;
   assign bus.wdata_in     = bus.HWDATAS;
   assign bus.wuser_in     = bus.HWUSERS;
   assign bus.held_tran_in = held_tran;

   always_comb begin
      bus.HREADYOUTS = 1'b1;
      bus.HRESPS     = HRESP_OKAY;
      case (state_q)
         ST_PEND: bus.HREADYOUTS = 1'b0;
         ST_DATA: begin
            bus.HREADYOUTS = bus.readyout_in;
            bus.HRESPS     = bus.resp_in;
         end
         default: begin
            bus.HREADYOUTS = 1'b1;
            bus.HRESPS     = HRESP_OKAY;
         end
      endcase
   end

endmodule

// File: tb/tb_l1_ahb_mtx_in_stg.sv
// Directed bench for the AHB matrix input stage: accept, stall/hold, SEQ promotion,
// data-phase wait states, two-cycle ERROR and asynchronous reset.
module tb_l1_ahb_mtx_in_stg;
   import l1_ahb_mtx_pkg::*;

   logic HCLK;
   logic HRESETn;
   int   total = 0;
   int   bad   = 0;

   l1_ahb_mtx_in_stg_if bus_if ();

   l1_ahb_mtx_in_stg dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus_if)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic drive_idle();
      bus_if.HSELS       = 1'b0;
      bus_if.HADDRS      = 32'h0;
      bus_if.HAUSERS     = 32'h0;
      bus_if.HWUSERS     = 32'h0;
      bus_if.HWDATAS     = 32'h0;
      bus_if.HTRANSS     = HTRANS_IDLE;
      bus_if.HWRITES     = 1'b0;
      bus_if.HSIZES      = 3'b010;
      bus_if.HBURSTS     = HBURST_SINGLE;
      bus_if.HPROTS      = 4'b0011;
      bus_if.HMASTERS    = 4'h0;
      bus_if.HMASTLOCKS  = 1'b0;
      bus_if.HREADYS     = 1'b1;
      bus_if.active_in   = 1'b0;
      bus_if.hready_in   = 1'b1;
      bus_if.readyout_in = 1'b1;
      bus_if.resp_in     = HRESP_OKAY;
   endtask

   task automatic drive_req(input logic [31:0] a, input logic [1:0] tr,
                            input logic w, input logic [2:0] b);
      bus_if.HSELS   = 1'b1;
      bus_if.HADDRS  = a;
      bus_if.HTRANSS = tr;
      bus_if.HWRITES = w;
      bus_if.HBURSTS = b;
      bus_if.HREADYS = 1'b1;
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      drive_idle();
      repeat (2) @(negedge HCLK);
      drive_req(32'h1234_5678, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE);
      bus_if.active_in = 1'b1;
      #1;
      total++; if (bus_if.held_tran_in !== 1'b0) begin bad++; $display("FAIL rst_held: got %b want 0", bus_if.held_tran_in); end
      total++; if (bus_if.HREADYOUTS !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus_if.HREADYOUTS); end
      total++; if (bus_if.HRESPS !== 2'b00) begin bad++; $display("FAIL rst_resp: got %b want 00", bus_if.HRESPS); end
      total++; if (bus_if.addr_in !== 32'h1234_5678) begin bad++; $display("FAIL rst_addr_live: got %h want 12345678", bus_if.addr_in); end
      @(negedge HCLK);
      drive_idle();
      HRESETn = 1'b1;
      @(negedge HCLK);
      #1;
      total++; if (bus_if.HREADYOUTS !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", bus_if.HREADYOUTS); end
      total++; if (bus_if.held_tran_in !== 1'b0) begin bad++; $display("FAIL post_rst_held: got %b want 0", bus_if.held_tran_in); end
      $display("test_reset: complete");
   endtask

   task automatic test_nonseq_accept();
      @(negedge HCLK);
      drive_req(32'h2000_0000, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE);
      bus_if.HMASTLOCKS = 1'b1;
      bus_if.active_in  = 1'b1;
      #1;
      total++; if (bus_if.held_tran_in !== 1'b1) begin bad++; $display("FAIL acc_held: got %b want 1", bus_if.held_tran_in); end
      total++; if (bus_if.HREADYOUTS !== 1'b1) begin bad++; $display("FAIL acc_ready_req: got %b want 1", bus_if.HREADYOUTS); end
      total++; if (bus_if.addr_in !== 32'h2000_0000) begin bad++; $display("FAIL acc_addr: got %h want 20000000", bus_if.addr_in); end
      total++; if (bus_if.write_in !== 1'b1 || bus_if.trans_in !== 2'b10 || bus_if.sel_in !== 1'b1) begin
         bad++; $display("FAIL acc_ctrl: got w=%b t=%b s=%b want w=1 t=10 s=1", bus_if.write_in, bus_if.trans_in, bus_if.sel_in); end
      total++; if (bus_if.mastlock_in !== 1'b1) begin bad++; $display("FAIL acc_lock: got %b want 1", bus_if.mastlock_in); end
      @(negedge HCLK);
      drive_idle();
      bus_if.resp_in = HRESP_ERROR;
      bus_if.HWDATAS = 32'hCAFE_F00D;
      bus_if.HWUSERS = 32'h0000_00A5;
      #1;
      total++; if (bus_if.HRESPS !== 2'b01) begin bad++; $display("FAIL acc_in_data: got %b want 01", bus_if.HRESPS); end
      total++; if (bus_if.held_tran_in !== 1'b0) begin bad++; $display("FAIL acc_held_after: got %b want 0", bus_if.held_tran_in); end
      total++; if (bus_if.HREADYOUTS !== 1'b1) begin bad++; $display("FAIL acc_ready_data: got %b want 1", bus_if.HREADYOUTS); end
      total++; if (bus_if.wdata_in !== 32'hCAFE_F00D || bus_if.wuser_in !== 32'h0000_00A5) begin
         bad++; $display("FAIL acc_wdata: got %h/%h want cafef00d/000000a5", bus_if.wdata_in, bus_if.wuser_in); end
      @(negedge HCLK);
      #1;
      total++; if (bus_if.HRESPS !== 2'b00) begin bad++; $display("FAIL acc_back_idle: got %b want 00", bus_if.HRESPS); end
      total++; if (bus_if.HREADYOUTS !== 1'b1) begin bad++; $display("FAIL acc_ready_idle: got %b want 1", bus_if.HREADYOUTS); end
      bus_if.resp_in = HRESP_OKAY;
      $display("test_nonseq_accept: write 20000000 complete");
   endtask

   task automatic test_pend_stall();
      @(negedge HCLK);
      drive_req(32'h4000_0010, HTRANS_NONSEQ, 1'b0, HBURST_INCR4);
      bus_if.HMASTLOCKS = 1'b1;
      bus_if.active_in  = 1'b0;
      #1;
      total++; if (bus_if.held_tran_in !== 1'b1) begin bad++; $display("FAIL pend_req_held: got %b want 1", bus_if.held_tran_in); end
      total++; if (bus_if.HREADYOUTS !== 1'b1) begin bad++; $display("FAIL pend_req_ready: got %b want 1", bus_if.HREADYOUTS); end
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         bus_if.HADDRS     = 32'h4000_0100 + 32'(i * 4);
         bus_if.HMASTLOCKS = 1'b0;
         bus_if.HBURSTS    = HBURST_SINGLE;
         bus_if.active_in  = (i == 2);
         #1;
         total++; if (bus_if.HREADYOUTS !== 1'b0) begin bad++; $display("FAIL pend_ready[%0d]: got %b want 0", i, bus_if.HREADYOUTS); end
         total++; if (bus_if.addr_in !== 32'h4000_0010) begin bad++; $display("FAIL pend_addr[%0d]: got %h want 40000010", i, bus_if.addr_in); end
         total++; if (bus_if.sel_in !== 1'b1 || bus_if.held_tran_in !== 1'b1) begin
            bad++; $display("FAIL pend_sel[%0d]: got sel=%b held=%b want 1/1", i, bus_if.sel_in, bus_if.held_tran_in); end
         total++; if (bus_if.trans_in !== 2'b10 || bus_if.burst_in !== 3'b011 || bus_if.write_in !== 1'b0) begin
            bad++; $display("FAIL pend_ctrl[%0d]: got t=%b b=%b w=%b want 10/011/0", i, bus_if.trans_in, bus_if.burst_in, bus_if.write_in); end
         total++; if (bus_if.mastlock_in !== 1'b1) begin bad++; $display("FAIL pend_lock[%0d]: got %b want 1", i, bus_if.mastlock_in); end
      end
      @(negedge HCLK);
      drive_idle();
      bus_if.resp_in = HRESP_ERROR;
      #1;
      total++; if (bus_if.HRESPS !== 2'b01) begin bad++; $display("FAIL pend_to_data: got %b want 01", bus_if.HRESPS); end
      total++; if (bus_if.held_tran_in !== 1'b0) begin bad++; $display("FAIL pend_held_after: got %b want 0", bus_if.held_tran_in); end
      bus_if.resp_in = HRESP_OKAY;
      $display("test_pend_stall: read 40000010 complete");
   endtask

   task automatic test_seq_hold();
      @(negedge HCLK);
      drive_req(32'h3000_0004, HTRANS_SEQ, 1'b1, HBURST_INCR4);
      bus_if.active_in = 1'b0;
      #1;
      total++; if (bus_if.trans_in !== 2'b11 || bus_if.burst_in !== 3'b011) begin
         bad++; $display("FAIL seq_live: got t=%b b=%b want 11/011", bus_if.trans_in, bus_if.burst_in); end
      for (int i = 0; i < 2; i++) begin
         @(negedge HCLK);
         bus_if.HREADYS   = 1'b0;
         bus_if.active_in = (i == 1);
         #1;
         total++; if (bus_if.trans_in !== 2'b10 || bus_if.burst_in !== 3'b001) begin
            bad++; $display("FAIL seq_held[%0d]: got t=%b b=%b want 10/001", i, bus_if.trans_in, bus_if.burst_in); end
         total++; if (bus_if.addr_in !== 32'h3000_0004 || bus_if.HREADYOUTS !== 1'b0) begin
            bad++; $display("FAIL seq_addr[%0d]: got %h rdy=%b want 30000004/0", i, bus_if.addr_in, bus_if.HREADYOUTS); end
      end
      @(negedge HCLK);
      drive_idle();
      #1;
      total++; if (bus_if.HREADYOUTS !== 1'b1 || bus_if.held_tran_in !== 1'b0) begin
         bad++; $display("FAIL seq_data: got rdy=%b held=%b want 1/0", bus_if.HREADYOUTS, bus_if.held_tran_in); end
      $display("test_seq_hold: seq 30000004 complete");
   endtask

   task automatic test_data_wait();
      @(negedge HCLK);
      drive_req(32'h5000_0000, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE);
      bus_if.active_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge HCLK);
         drive_idle();
         bus_if.HREADYS     = 1'b0;
         bus_if.readyout_in = 1'b0;
         #1;
         total++; if (bus_if.HREADYOUTS !== 1'b0 || bus_if.held_tran_in !== 1'b0) begin
            bad++; $display("FAIL dw_wait[%0d]: got rdy=%b held=%b want 0/0", i, bus_if.HREADYOUTS, bus_if.held_tran_in); end
      end
      @(negedge HCLK);
      drive_req(32'h5000_0004, HTRANS_NONSEQ, 1'b0, HBURST_SINGLE);
      bus_if.readyout_in = 1'b1;
      bus_if.active_in   = 1'b0;
      #1;
      total++; if (bus_if.HREADYOUTS !== 1'b1 || bus_if.held_tran_in !== 1'b1) begin
         bad++; $display("FAIL dw_done: got rdy=%b held=%b want 1/1", bus_if.HREADYOUTS, bus_if.held_tran_in); end
      @(negedge HCLK);
      bus_if.HADDRS  = 32'h5000_0FFC;
      bus_if.HREADYS = 1'b0;
      #1;
      total++; if (bus_if.HREADYOUTS !== 1'b0 || bus_if.addr_in !== 32'h5000_0004) begin
         bad++; $display("FAIL dw_pend: got rdy=%b addr=%h want 0/50000004", bus_if.HREADYOUTS, bus_if.addr_in); end
      bus_if.active_in = 1'b1;
      @(negedge HCLK);
      drive_idle();
      #1;
      total++; if (bus_if.HREADYOUTS !== 1'b1 || bus_if.held_tran_in !== 1'b0) begin
         bad++; $display("FAIL dw_data2: got rdy=%b held=%b want 1/0", bus_if.HREADYOUTS, bus_if.held_tran_in); end
      $display("test_data_wait: 50000000/50000004 complete");
   endtask

   task automatic test_error_resp();
      @(negedge HCLK);
      drive_req(32'h6000_0000, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE);
      bus_if.active_in = 1'b1;
      bus_if.resp_in   = HRESP_ERROR;
      #1;
      total++; if (bus_if.HRESPS !== 2'b00) begin bad++; $display("FAIL err_idle: got %b want 00", bus_if.HRESPS); end
      @(negedge HCLK);
      drive_idle();
      bus_if.resp_in     = HRESP_ERROR;
      bus_if.readyout_in = 1'b0;
      #1;
      total++; if (bus_if.HRESPS !== 2'b01 || bus_if.HREADYOUTS !== 1'b0) begin
         bad++; $display("FAIL err_cyc1: got resp=%b rdy=%b want 01/0", bus_if.HRESPS, bus_if.HREADYOUTS); end
      @(negedge HCLK);
      bus_if.readyout_in = 1'b1;
      #1;
      total++; if (bus_if.HRESPS !== 2'b01 || bus_if.HREADYOUTS !== 1'b1) begin
         bad++; $display("FAIL err_cyc2: got resp=%b rdy=%b want 01/1", bus_if.HRESPS, bus_if.HREADYOUTS); end
      @(negedge HCLK);
      #1;
      total++; if (bus_if.HRESPS !== 2'b00) begin bad++; $display("FAIL err_after: got %b want 00", bus_if.HRESPS); end
      bus_if.resp_in = HRESP_OKAY;
      $display("test_error_resp: error 60000000 complete");
   endtask

   task automatic test_async_reset();
      @(negedge HCLK);
      drive_req(32'h7000_0000, HTRANS_NONSEQ, 1'b1, HBURST_SINGLE);
      bus_if.active_in = 1'b0;
      @(negedge HCLK);
      #1;
      total++; if (bus_if.HREADYOUTS !== 1'b0 || bus_if.held_tran_in !== 1'b1) begin
         bad++; $display("FAIL ar_pend: got rdy=%b held=%b want 0/1", bus_if.HREADYOUTS, bus_if.held_tran_in); end
      bus_if.HSELS  = 1'b0;
      bus_if.HADDRS = 32'h0000_0077;
      HRESETn = 1'b0;
      #1;
      total++; if (bus_if.held_tran_in !== 1'b0) begin bad++; $display("FAIL ar_held: got %b want 0", bus_if.held_tran_in); end
      total++; if (bus_if.HREADYOUTS !== 1'b1 || bus_if.HRESPS !== 2'b00) begin
         bad++; $display("FAIL ar_resp: got rdy=%b resp=%b want 1/00", bus_if.HREADYOUTS, bus_if.HRESPS); end
      total++; if (bus_if.addr_in !== 32'h0000_0077 || bus_if.sel_in !== 1'b0) begin
         bad++; $display("FAIL ar_live: got addr=%h sel=%b want 00000077/0", bus_if.addr_in, bus_if.sel_in); end
      @(negedge HCLK);
      drive_idle();
      HRESETn = 1'b1;
      @(negedge HCLK);
      #1;
      total++; if (bus_if.HREADYOUTS !== 1'b1 || bus_if.held_tran_in !== 1'b0) begin
         bad++; $display("FAIL ar_release: got rdy=%b held=%b want 1/0", bus_if.HREADYOUTS, bus_if.held_tran_in); end
      $display("test_async_reset: reset in pend complete");
   endtask

   initial begin
      test_reset();
      test_nonseq_accept();
      test_pend_stall();
      test_seq_hold();
      test_data_wait();
      test_error_resp();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
